// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port RAM: write-collision
// mode codes, clear-sequencer state encoding and the parity helper.
package ram_pkg;

  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  localparam int unsigned PARITY_MAX_W = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_e;

  // Even parity of a word; callers zero-extend to PARITY_MAX_W, which
  // leaves the parity unchanged.
  function automatic logic parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Post-reset clear sequencer: walks every address once, writing the init
// word, then hands the array over to normal accesses.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  ram_state_e    r_state;
  ram_state_e    w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;

  // State and pointer registers; reset restarts the clear from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state and outputs; the last address is written on the cycle the
  // FSM decides to leave INIT.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    clr_we      = 1'b0;
    init_busy   = rst;
    unique case (r_state)
      ST_INIT: begin
        init_busy = 1'b1;
        clr_we    = ~rst;
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign clr_addr = r_ptr;

endmodule

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with selectable read latency
// (0/1/2), write-collision mode, post-reset clear and an output valid.
// Optional even-parity storage and checking when RAM_PARITY_EN is defined.
module ram_param
  import ram_pkg::*;
#(
  parameter int unsigned   AW         = 4,
  parameter int unsigned   DW         = 8,
  parameter int unsigned   READ_LAT   = 1,
  parameter int unsigned   WRITE_MODE = 0,
  parameter logic [DW-1:0] INIT_VAL   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          init_busy
`ifdef RAM_PARITY_EN
  ,
  output logic          perr
`endif
);

  localparam int unsigned DEPTH = 2 ** AW;
`ifdef RAM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif

  if (READ_LAT > 2) begin : g_bad_read_lat
    $error("ram_param: READ_LAT must be 0, 1 or 2");
  end

  logic [MW-1:0] r_mem [DEPTH];

  logic          w_init_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic          w_acc;
  logic [MW-1:0] w_wr_word;
  logic [MW-1:0] w_init_word;
  logic [MW-1:0] w_rd_word;
  logic [MW-1:0] w_out_word;
  logic          w_out_vld;

  ram_clr_seq #(
    .AW(AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .init_busy(w_init_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_acc = en & ~w_init_busy;

`ifdef RAM_PARITY_EN
  assign w_wr_word   = {parity(PARITY_MAX_W'(d)), d};
  assign w_init_word = {parity(PARITY_MAX_W'(INIT_VAL)), INIT_VAL};
`else
  assign w_wr_word   = d;
  assign w_init_word = INIT_VAL;
`endif

  assign w_rd_word = r_mem[a];

  // Array write port, shared between the clear sequencer and user writes.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= w_init_word;
    end else if (w_acc && we) begin
      r_mem[a] <= w_wr_word;
    end
  end

  if (READ_LAT == 0) begin : g_lat0
    assign w_out_word = w_rd_word;
    assign w_out_vld  = w_acc;
  end else begin : g_lat_reg
    logic [MW-1:0] r_s1_word;
    logic          r_s1_vld;

    // First read stage: loads only on an accepted access, resolving
    // same-address write collisions by WRITE_MODE.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_word <= '0;
        r_s1_vld  <= 1'b0;
      end else begin
        r_s1_vld <= w_acc & ~(we & (WRITE_MODE == WM_NO_CHANGE));
        if (w_acc) begin
          if (!we) begin
            r_s1_word <= w_rd_word;
          end else if (WRITE_MODE == WM_WRITE_FIRST) begin
            r_s1_word <= w_wr_word;
          end else if (WRITE_MODE == WM_READ_FIRST) begin
            r_s1_word <= w_rd_word;
          end
        end
      end
    end

    if (READ_LAT == 1) begin : g_lat1
      assign w_out_word = r_s1_word;
      assign w_out_vld  = r_s1_vld;
    end else begin : g_lat2
      logic [MW-1:0] r_s2_word;
      logic          r_s2_vld;

      // Output register stage: follows stage one every cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_word <= '0;
          r_s2_vld  <= 1'b0;
        end else begin
          r_s2_word <= r_s1_word;
          r_s2_vld  <= r_s1_vld;
        end
      end

      assign w_out_word = r_s2_word;
      assign w_out_vld  = r_s2_vld;
    end
  end

  assign dout      = w_out_word[DW-1:0];
  assign dout_vld  = w_out_vld;
  assign init_busy = w_init_busy;

`ifdef RAM_PARITY_EN
  assign perr = w_out_vld &
                (w_out_word[DW] != parity(PARITY_MAX_W'(w_out_word[DW-1:0])));
`endif

endmodule

// File: tb/tb_ram_param.sv
// Scoreboard bench for ram_param: five instances (latency 0/1/2 read-first,
// latency 1 write-first, latency 1 no-change) share one stimulus stream.
// Parity checks are included when RAM_PARITY_EN is defined.
module tb_ram_param;

  localparam int unsigned NDUT = 5;
  localparam int unsigned LAT_CFG [NDUT] = '{0, 1, 2, 1, 1};
  localparam int unsigned WM_CFG  [NDUT] = '{0, 0, 0, 1, 2};

  typedef struct {
    logic [7:0]  data;
    bit          perr;
    int unsigned due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       we  = 1'b0;
  logic [3:0] a   = '0;
  logic [7:0] d   = '0;

  logic [7:0] dout_w [NDUT];
  logic       vld_w  [NDUT];
  logic       busy_w [NDUT];
`ifdef RAM_PARITY_EN
  logic       perr_w [NDUT];
`endif

  exp_t        q [NDUT][$];
  logic [7:0]  model [16];
  bit          bad [NDUT][16];
  logic [7:0]  hold [NDUT];
  int unsigned cyc      = 0;
  int unsigned rst_last = 0;
  bit          mon_on   = 1'b0;
  bit          rst_prev = 1'b1;
  int          n_chk    = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ram_param #(
      .AW        (4),
      .DW        (8),
      .READ_LAT  (LAT_CFG[g]),
      .WRITE_MODE(WM_CFG[g]),
      .INIT_VAL  (8'h00)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .we       (we),
      .a        (a),
      .d        (d),
      .dout     (dout_w[g]),
      .dout_vld (vld_w[g]),
      .init_busy(busy_w[g])
`ifdef RAM_PARITY_EN
      ,
      .perr     (perr_w[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One stimulus cycle; expected read results are pushed as it is driven.
  task automatic drive(input bit r, input bit e, input bit w,
                       input logic [3:0] ai, input logic [7:0] di);
    bit         acc;
    logic [7:0] old;
    exp_t       x;
    @(posedge clk);
    #1;
    rst = r; en = e; we = w; a = ai; d = di;
    if (r) begin
      rst_last = cyc;
      for (int i = 0; i < NDUT; i++) begin
        while (q[i].size() > 0 && q[i][$].due > cyc) void'(q[i].pop_back());
        for (int k = 0; k < 16; k++) bad[i][k] = 1'b0;
      end
      for (int k = 0; k < 16; k++) model[k] = 8'h00;
    end
    acc = e && !r && (cyc > rst_last + 16);
    if (acc) begin
      old = model[ai];
      for (int i = 0; i < NDUT; i++) begin
        x.due = cyc + LAT_CFG[i];
        if (!w || LAT_CFG[i] == 0 || WM_CFG[i] == 0) begin
          x.data = old; x.perr = bad[i][ai]; q[i].push_back(x);
        end else if (WM_CFG[i] == 1) begin
          x.data = di; x.perr = 1'b0; q[i].push_back(x);
        end
      end
      if (w) begin
        model[ai] = di;
        for (int i = 0; i < NDUT; i++) bad[i][ai] = 1'b0;
      end
    end
  endtask

  // Monitor: checks valid, busy, data, parity and hold behaviour mid-cycle.
  always @(negedge clk) begin
    bit   ev;
    bit   exp_busy;
    exp_t x;
    if (mon_on) begin
      exp_busy = rst || (cyc <= rst_last + 16);
      if (rst_prev) begin
        for (int i = 0; i < NDUT; i++) hold[i] = 8'h00;
      end
      for (int i = 0; i < NDUT; i++) begin
        ev = (q[i].size() > 0) && (q[i][0].due == cyc);
        chk($sformatf("vld%0d", i), 32'(vld_w[i]), 32'(ev));
        chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(exp_busy));
        if (ev) begin
          x = q[i].pop_front();
          chk($sformatf("dout%0d", i), 32'(dout_w[i]), 32'(x.data));
`ifdef RAM_PARITY_EN
          chk($sformatf("perr%0d", i), 32'(perr_w[i]), 32'(x.perr));
`endif
          hold[i] = x.data;
        end else begin
`ifdef RAM_PARITY_EN
          chk($sformatf("perr_idle%0d", i), 32'(perr_w[i]), 32'd0);
`endif
          if (LAT_CFG[i] != 0) chk($sformatf("hold%0d", i), 32'(dout_w[i]), 32'(hold[i]));
        end
      end
    end
    rst_prev = rst;
  end

  initial begin
    for (int k = 0; k < 16; k++) model[k] = 8'h00;
    for (int i = 0; i < NDUT; i++) hold[i] = 8'h00;
    // Power-up reset, accesses during INIT, and a reset mid-INIT.
    drive(1, 0, 0, 4'h0, 8'h00);
    drive(1, 0, 0, 4'h0, 8'h00);
    mon_on = 1'b1;
    for (int k = 0; k < 5; k++) drive(0, k == 1, 1, 4'h2, 8'hFF);
    drive(1, 0, 0, 4'h0, 8'h00);
    for (int k = 0; k < 16; k++) drive(0, k == 3, 1, 4'h2, 8'hFF);
    // First read lands on the cycle busy falls; all words cleared.
    for (int k = 0; k < 16; k++) drive(0, 1, 0, 4'(k), 8'h00);
    // Write then read back-to-back.
    drive(0, 1, 1, 4'h3, 8'hA5);
    drive(0, 1, 0, 4'h3, 8'h00);
    // Collision modes on address 5, then idle so the hold value is checked.
    drive(0, 1, 1, 4'h5, 8'h11);
    drive(0, 1, 0, 4'h5, 8'h00);
    drive(0, 1, 1, 4'h5, 8'h22);
    drive(0, 0, 0, 4'h5, 8'h00);
    drive(0, 1, 0, 4'h5, 8'h00);
    drive(0, 0, 0, 4'h0, 8'h00);
    drive(0, 0, 0, 4'h0, 8'h00);
    // Extreme addresses.
    drive(0, 1, 1, 4'hF, 8'h5A);
    drive(0, 1, 0, 4'hF, 8'h00);
    drive(0, 1, 1, 4'h0, 8'hC3);
    drive(0, 1, 0, 4'h0, 8'h00);
    drive(0, 1, 0, 4'hF, 8'h00);
    // Random mixed traffic.
    for (int k = 0; k < 40; k++)
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
`ifdef RAM_PARITY_EN
    // Corrupt the stored parity bit of address 7 in every instance.
    drive(0, 1, 1, 4'h7, 8'h0F);
    drive(0, 0, 0, 4'h0, 8'h00);
    g_dut[0].u_dut.r_mem[7][8] = ~g_dut[0].u_dut.r_mem[7][8];
    g_dut[1].u_dut.r_mem[7][8] = ~g_dut[1].u_dut.r_mem[7][8];
    g_dut[2].u_dut.r_mem[7][8] = ~g_dut[2].u_dut.r_mem[7][8];
    g_dut[3].u_dut.r_mem[7][8] = ~g_dut[3].u_dut.r_mem[7][8];
    g_dut[4].u_dut.r_mem[7][8] = ~g_dut[4].u_dut.r_mem[7][8];
    for (int i = 0; i < NDUT; i++) bad[i][7] = 1'b1;
    drive(0, 1, 0, 4'h7, 8'h00);
    drive(0, 1, 0, 4'h3, 8'h00);
    drive(0, 0, 0, 4'h0, 8'h00);
    drive(0, 0, 0, 4'h0, 8'h00);
`endif
    // Reset right after a read: the latency-2 result must never appear.
    drive(0, 1, 1, 4'h3, 8'h77);
    drive(0, 1, 0, 4'h3, 8'h00);
    drive(1, 0, 0, 4'h0, 8'h00);
    for (int k = 0; k < 16; k++) drive(0, 0, 0, 4'h0, 8'h00);
    drive(0, 1, 0, 4'h3, 8'h00);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 4'h0, 8'h00);
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) chk($sformatf("drain%0d", i), 32'(q[i].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
